// File: rtl/matrix_op_sequencer_if.sv
// Bundle of command, bank, ALU, result-write and status signals around
// matrix_op_sequencer. The master modport is the sequencer itself; the slave
// modport is its surroundings (command decoder, register banks, ALU).
//
// Handshake: start is a single-cycle strobe that is only sampled while the
// sequencer is idle; anything presented while busy or during the done cycle
// is dropped. done (with err) is a one-cycle completion pulse, and w_en
// qualifies w_addr/w_data for exactly one cycle per written element.
interface matrix_op_sequencer_if #(
  parameter int DW = 8,
  parameter int AW = 5
);
  logic          start;
  logic [2:0]    op;
  logic [2:0]    size;
  logic [AW-1:0] a_addr;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] a_rdata;
  logic [DW-1:0] b_rdata;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_r1;
  logic [DW-1:0] alu_r2;
  logic [2:0]    alu_size;
  logic [DW-1:0] alu_res;
  logic          w_en;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          busy;
  logic          done;
  logic          err;
  logic [2:0]    dbg_state;

  modport master (
    input  start, op, size, a_rdata, b_rdata, alu_res,
    output a_addr, b_addr, alu_op, alu_r1, alu_r2, alu_size,
           w_en, w_addr, w_data, busy, done, err, dbg_state
  );

  modport slave (
    output start, op, size, a_rdata, b_rdata, alu_res,
    input  a_addr, b_addr, alu_op, alu_r1, alu_r2, alu_size,
           w_en, w_addr, w_data, busy, done, err, dbg_state
  );
endinterface

// File: rtl/matrix_op_sequencer.sv
// Control FSM that walks the matrix ALU over N x N operands (N = 2..5).
// Elementwise ops take RD/EX per element; multM takes N RD/EX pairs to build
// a dot product in an accumulator and one WR to store it. Bank reads are
// synchronous: the address driven in RD returns data in the following EX.
// Element address is row*5 + col for every bank.
//
// Build option: define MATSEQ_SAT_EN to make the multM accumulator saturate
// to the signed DW-bit range instead of wrapping.
module matrix_op_sequencer #(
  parameter int DW   = 8,
  parameter int AW   = 5,
  parameter int NMIN = 2,
  parameter int NMAX = 5
) (
  input logic                    clk,
  input logic                    rst,
  matrix_op_sequencer_if.master  bus
);

  localparam logic [2:0] OP_MULTM  = 3'b010;
  localparam logic [2:0] OP_MULTMR = 3'b011;
  localparam logic [2:0] OP_DETM   = 3'b100;
  localparam logic [2:0] OP_TRANSM = 3'b101;
  localparam logic [2:0] OP_CLEAR  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_EX   = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [2:0]    size_q, size_d;
  logic [2:0]    i_q, i_d;
  logic [2:0]    j_q, j_d;
  logic [2:0]    k_q, k_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          err_q, err_d;

  logic          is_mult;
  logic          last_col;
  logic          last_row;
  logic          last_k;
  logic [DW-1:0] acc_base;
  logic [DW:0]   acc_sum;
  logic [DW-1:0] acc_next;

  function automatic logic [AW-1:0] elem_addr(input logic [2:0] r, input logic [2:0] c);
    return AW'(r) * AW'(5) + AW'(c);
  endfunction

  assign is_mult  = (op_q == OP_MULTM);
  assign last_col = (j_q == size_q - 3'd1);
  assign last_row = (i_q == size_q - 3'd1);
  assign last_k   = (k_q == size_q - 3'd1);

  // Dot-product step: restart at k==0, then add one product per EX with one
  // guard bit so overflow can be detected for the saturating build.
  always_comb begin
    acc_base = (k_q == 3'd0) ? '0 : acc_q;
    acc_sum  = {acc_base[DW-1], acc_base} + {bus.alu_res[DW-1], bus.alu_res};
`ifdef MATSEQ_SAT_EN
    if (acc_sum[DW] != acc_sum[DW-1]) begin
      acc_next = acc_sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      acc_next = acc_sum[DW-1:0];
    end
`else
    acc_next = acc_sum[DW-1:0];
`endif
  end

  // State and datapath registers; reset also aborts any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      size_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      size_q  <= size_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  // Next-state, index stepping and all outputs for the current state.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    size_d  = size_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    err_d   = err_q;

    bus.a_addr    = '0;
    bus.b_addr    = '0;
    bus.alu_op    = '0;
    bus.alu_r1    = '0;
    bus.alu_r2    = '0;
    bus.alu_size  = size_q;
    bus.w_en      = 1'b0;
    bus.w_addr    = '0;
    bus.w_data    = '0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    bus.dbg_state = state_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d   = bus.op;
          size_d = bus.size;
          i_d    = '0;
          j_d    = '0;
          k_d    = '0;
          if (bus.size < 3'(NMIN) || bus.size > 3'(NMAX) || bus.op == OP_DETM) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_RD;
          end
        end
      end

      S_RD: begin
        bus.busy = 1'b1;
        if (is_mult) begin
          bus.a_addr = elem_addr(i_q, k_q);
          bus.b_addr = elem_addr(k_q, j_q);
        end else begin
          bus.a_addr = (op_q == OP_TRANSM) ? elem_addr(j_q, i_q) : elem_addr(i_q, j_q);
          bus.b_addr = (op_q == OP_MULTMR) ? '0 : elem_addr(i_q, j_q);
        end
        state_d = S_EX;
      end

      S_EX: begin
        bus.busy   = 1'b1;
        bus.alu_r1 = bus.a_rdata;
        bus.alu_r2 = bus.b_rdata;
        if (is_mult) begin
          bus.alu_op = OP_MULTMR;
          acc_d      = acc_next;
          if (last_k) begin
            state_d = S_WR;
          end else begin
            k_d     = k_q + 3'd1;
            state_d = S_RD;
          end
        end else begin
          bus.alu_op = op_q;
          bus.w_en   = 1'b1;
          bus.w_addr = elem_addr(i_q, j_q);
          bus.w_data = (op_q == OP_CLEAR) ? '0 : bus.alu_res;
          if (!last_col) begin
            j_d     = j_q + 3'd1;
            state_d = S_RD;
          end else if (!last_row) begin
            j_d     = '0;
            i_d     = i_q + 3'd1;
            state_d = S_RD;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_WR: begin
        bus.busy   = 1'b1;
        bus.w_en   = 1'b1;
        bus.w_addr = elem_addr(i_q, j_q);
        bus.w_data = acc_q;
        k_d        = '0;
        if (!last_col) begin
          j_d     = j_q + 3'd1;
          state_d = S_RD;
        end else if (!last_row) begin
          j_d     = '0;
          i_d     = i_q + 3'd1;
          state_d = S_RD;
        end else begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        bus.done = 1'b1;
        bus.err  = err_q;
        err_d    = 1'b0;
        i_d      = '0;
        j_d      = '0;
        k_d      = '0;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
